// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared fetch-path types and constants
package rv_pkg;

    localparam int          ILEN        = 32;
    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular prefetch FIFO of fetch entries, flush beats push/pop
module fetch_queue
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t entry,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A full queue may still accept a push when the head leaves in the same cycle;
    // the write lands in the slot being vacated.
    assign do_push = push & ~flush & (~full | (pop & ~empty));
    assign do_pop  = pop & ~flush & ~empty;

    // Entry storage carries no reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= entry;
        end
    end

    // Pointers and occupancy; flush empties the queue in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and prefetch control; FETCH_MISALIGN_TRAP_EN adds misalign halt
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        if_misalign
`endif
);

    logic [31:0]  pc;
    logic [31:0]  target;
    logic         halted;
    logic         pop;
    logic         push;
    logic         full;
    logic         empty;
    fetch_entry_t head;
    fetch_entry_t entry;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target = redirect_pc;

    // A misaligned redirect parks the fetcher until an aligned redirect arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (redirect_valid) begin
            halted <= |redirect_pc[1:0];
        end
    end

    assign if_misalign = halted;
`else
    assign target = redirect_pc & ~32'h3;
    assign halted = 1'b0;
`endif

    assign pop   = if_valid & if_ready;
    assign push  = ~redirect_valid & ~halted & (~full | pop);
    assign entry = '{pc: pc, instr: rom_data};

    // PC advances one word per fetched entry; redirect overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= target;
        end else if (push) begin
            pc <= pc + 32'(INSTR_BYTES);
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop & ~redirect_valid),
        .flush (redirect_valid),
        .entry (entry),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign rom_addr = pc;
    assign if_valid = ~empty;
    assign if_pc    = empty ? 32'h0 : head.pc;
    assign if_instr = empty ? 32'h0 : head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue-based reference model
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        if_misalign;
`endif

    logic [63:0] mq[$];
    logic [31:0] mpc;
    bit          mhalt;
    int          tests;
    int          fails;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .if_misalign    (if_misalign)
`endif
    );

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    assign rom_data = rom_fn(rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        mpc   = RESET_PC;
        mhalt = 1'b0;
    endtask

    task automatic model_edge();
        if (redirect_valid) begin
            mq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
            mpc   = redirect_pc;
            mhalt = (redirect_pc[1:0] != 2'b00);
`else
            mpc   = redirect_pc & ~32'h3;
`endif
        end else begin
            if (mq.size() > 0 && if_ready) void'(mq.pop_front());
            if (!mhalt && mq.size() < DEPTH) begin
                mq.push_back({mpc, rom_fn(mpc)});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ein;
        ev  = (mq.size() > 0);
        epc = ev ? mq[0][63:32] : 32'h0;
        ein = ev ? mq[0][31:0]  : 32'h0;
        tests++;
        assert (if_valid === ev) else begin
            fails++;
            $error("FAIL %s if_valid got=%0b exp=%0b t=%0t", tag, if_valid, ev, $time);
        end
        tests++;
        assert (if_pc === epc) else begin
            fails++;
            $error("FAIL %s if_pc got=%h exp=%h t=%0t", tag, if_pc, epc, $time);
        end
        tests++;
        assert (if_instr === ein) else begin
            fails++;
            $error("FAIL %s if_instr got=%h exp=%h t=%0t", tag, if_instr, ein, $time);
        end
        tests++;
        assert (rom_addr === mpc) else begin
            fails++;
            $error("FAIL %s rom_addr got=%h exp=%h t=%0t", tag, rom_addr, mpc, $time);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        tests++;
        assert (if_misalign === mhalt) else begin
            fails++;
            $error("FAIL %s if_misalign got=%0b exp=%0b t=%0t", tag, if_misalign, mhalt, $time);
        end
`endif
    endtask

    task automatic step(input string tag, input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        check_outputs(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rpc;
        int          sel;
        tests          = 0;
        fails          = 0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) step("stream", 1'b0, 32'h0, 1'b1);

        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs("reset2");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step("stall", 1'b0, 32'h0, 1'b0);
        tests++;
        assert (rom_addr === 32'(4 * DEPTH)) else begin
            fails++;
            $error("FAIL stall_addr got=%h exp=%h", rom_addr, 32'(4 * DEPTH));
        end
        for (int i = 0; i < 5; i++) step("drain", 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 3; i++) step("fill", 1'b0, 32'h0, 1'b0);
        step("redir40", 1'b1, 32'h40, 1'b1);
        for (int i = 0; i < 3; i++) step("after40", 1'b0, 32'h0, 1'b1);

        step("redirwrap", 1'b1, 32'hFFFF_FFFC, 1'b1);
        for (int i = 0; i < 4; i++) step("wrap", 1'b0, 32'h0, 1'b1);

        step("redir42", 1'b1, 32'h42, 1'b1);
        for (int i = 0; i < 3; i++) step("after42", 1'b0, 32'h0, 1'b1);
        step("redir80", 1'b1, 32'h80, 1'b1);
        step("b2b", 1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 3; i++) step("after100", 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 3; i++) step("fill2", 1'b0, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        check_outputs("rst_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step("resume", 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       rpc = $urandom & ~32'h3;
                1:       rpc = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
                2:       rpc = $urandom;
                default: rpc = 32'(($urandom_range(0, 63)) << 2);
            endcase
            step("random", ($urandom_range(0, 7) == 0), rpc, ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
